// File: rtl/int_mul_var_pkg.sv
// Shared types and constants for the variable-latency multiplier controller.
package int_mul_var_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic A_LD     = 1'b0;
    localparam logic A_SHIFT  = 1'b1;
    localparam logic B_LD     = 1'b0;
    localparam logic B_SHIFT  = 1'b1;
    localparam logic RES_ZERO = 1'b0;
    localparam logic RES_ADD  = 1'b1;
    localparam logic ADD_KEEP = 1'b0;
    localparam logic ADD_SUM  = 1'b1;

    localparam int SHAMT_W      = 4;
    localparam int SHAMT_WINDOW = 8;

endpackage

// File: rtl/int_mul_var_shamt_enc.sv
// Picks the per-cycle shift amount from b's low bits so runs of zeros are
// skipped in one step; a set bit 0 always shifts by exactly one after adding.
module int_mul_var_shamt_enc
    import int_mul_var_pkg::*;
(
    input  logic [SHAMT_WINDOW-1:0] b_lsb,
    output logic [SHAMT_W-1:0]      shamt
);

    always_comb begin
        shamt = SHAMT_W'(SHAMT_WINDOW);
        // Descending scan so the lowest set bit wins.
        for (int i = SHAMT_WINDOW - 1; i >= 1; i--) begin
            if (b_lsb[i]) shamt = SHAMT_W'(i);
        end
        if (b_lsb[0]) shamt = SHAMT_W'(1);
    end

endmodule

// File: rtl/int_mul_var_ctrl.sv
// Control FSM for the iterative multiplier: load, shift/add until b empties
// or the shift count reaches NBITS, then present the product.
module int_mul_var_ctrl
    import int_mul_var_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    istream_val,
    output logic                    istream_rdy,
    output logic                    ostream_val,
    input  logic                    ostream_rdy,
    input  logic [SHAMT_WINDOW-1:0] b_lsb,
    input  logic                    b_zero,
    output logic                    a_mux_sel,
    output logic                    b_mux_sel,
    output logic                    result_mux_sel,
    output logic                    add_mux_sel,
    output logic                    a_en,
    output logic                    b_en,
    output logic                    result_en,
    output logic [SHAMT_W-1:0]      shamt
);

    localparam int CW = $clog2(NBITS) + 1;

    state_e              state, state_nxt;
    logic [CW-1:0]       count, count_nxt;
    logic [SHAMT_W-1:0]  enc_shamt;

    logic irdy_c, oval_c, amux_c, bmux_c, rmux_c, addm_c, aen_c, ben_c, ren_c;
    logic [SHAMT_W-1:0] shamt_c;

    int_mul_var_shamt_enc u_enc (
        .b_lsb (b_lsb),
        .shamt (enc_shamt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        irdy_c    = 1'b0;
        oval_c    = 1'b0;
        amux_c    = A_LD;
        bmux_c    = B_LD;
        rmux_c    = RES_ZERO;
        addm_c    = ADD_KEEP;
        aen_c     = 1'b0;
        ben_c     = 1'b0;
        ren_c     = 1'b0;
        shamt_c   = '0;
        case (state)
            IDLE: begin
                irdy_c = 1'b1;
                aen_c  = istream_val;
                ben_c  = istream_val;
                ren_c  = istream_val;
                if (istream_val) begin
                    state_nxt = CALC;
                    count_nxt = '0;
                end
            end
            CALC: begin
                // Exit is a pure check cycle; the datapath is left alone.
                if (b_zero || count >= CW'(NBITS)) begin
                    state_nxt = DONE;
                end else begin
                    aen_c     = 1'b1;
                    ben_c     = 1'b1;
                    ren_c     = 1'b1;
                    amux_c    = A_SHIFT;
                    bmux_c    = B_SHIFT;
                    rmux_c    = RES_ADD;
                    addm_c    = b_lsb[0] ? ADD_SUM : ADD_KEEP;
                    shamt_c   = enc_shamt;
                    count_nxt = count + CW'(enc_shamt);
                end
            end
            DONE: begin
                oval_c = 1'b1;
                if (ostream_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low for the whole time reset is held.
    assign istream_rdy    = reset_n & irdy_c;
    assign ostream_val    = reset_n & oval_c;
    assign a_mux_sel      = reset_n & amux_c;
    assign b_mux_sel      = reset_n & bmux_c;
    assign result_mux_sel = reset_n & rmux_c;
    assign add_mux_sel    = reset_n & addm_c;
    assign a_en           = reset_n & aen_c;
    assign b_en           = reset_n & ben_c;
    assign result_en      = reset_n & ren_c;
    assign shamt          = reset_n ? shamt_c : '0;

endmodule

// File: tb/tb_int_mul_var_ctrl.sv
// Directed bench: a small datapath model closes the b_lsb/b_zero loop and
// accumulates the product so latency, shift pattern and result are checked.
module tb_int_mul_var_ctrl;
    import int_mul_var_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        istream_val, istream_rdy, ostream_val, ostream_rdy;
    logic [7:0]  b_lsb;
    logic        b_zero;
    logic        a_mux_sel, b_mux_sel, result_mux_sel, add_mux_sel;
    logic        a_en, b_en, result_en;
    logic [3:0]  shamt;

    logic [31:0] in_a = '0, in_b = '0;
    logic [31:0] a_reg = '0, b_reg = '0, res_reg = '0;

    int nerr = 0;
    int nchk = 0;
    int shq[$];
    int addq[$];
    int lat;

    always #5 clk = ~clk;

    int_mul_var_ctrl #(.NBITS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .istream_val(istream_val), .istream_rdy(istream_rdy),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
        .b_lsb(b_lsb), .b_zero(b_zero),
        .a_mux_sel(a_mux_sel), .b_mux_sel(b_mux_sel),
        .result_mux_sel(result_mux_sel), .add_mux_sel(add_mux_sel),
        .a_en(a_en), .b_en(b_en), .result_en(result_en),
        .shamt(shamt)
    );

    assign b_lsb  = b_reg[7:0];
    assign b_zero = (b_reg == 32'd0);

    always @(posedge clk) begin
        if (a_en) a_reg <= a_mux_sel ? (a_reg << shamt) : in_a;
        if (b_en) b_reg <= b_mux_sel ? (b_reg >> shamt) : in_b;
        if (result_en)
            res_reg <= result_mux_sel ? (add_mux_sel ? res_reg + a_reg : res_reg) : 32'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {istream_rdy, ostream_val, a_mux_sel, b_mux_sel, result_mux_sel,
                add_mux_sel, a_en, b_en, result_en, shamt};
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic start_txn(input logic [31:0] a, input logic [31:0] b);
        in_a = a;
        in_b = b;
        istream_val = 1'b1;
        #1;
        chk("idle_accept", {istream_rdy, a_en, b_en, result_en, a_mux_sel, b_mux_sel, result_mux_sel}, 7'b1111000);
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
    endtask

    // Returns at the first negedge where ostream_val is high; lat is that cycle.
    task automatic wait_done(output int cyc);
        cyc = 1;
        shq.delete();
        addq.delete();
        while (!ostream_val && cyc < 100) begin
            if (a_en) begin
                shq.push_back(int'(shamt));
                addq.push_back(int'(add_mux_sel));
            end
            chk("count_bound", 64'(dut.count <= 6'd32), 64'd1);
            @(negedge clk);
            cyc++;
        end
        if (!ostream_val) chk("timeout", 64'(ostream_val), 64'd1);
        chk("done_enables", {a_en, b_en, result_en, istream_rdy}, 4'b0000);
    endtask

    initial begin
        int exp_sh[5];
        int ok_all;
        exp_sh = '{8, 8, 8, 7, 1};
        reset_n     = 1'b0;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_outs", 64'(outs()), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_count", 64'(dut.count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle_rdy", {istream_rdy, ostream_val, a_en}, 3'b100);
        @(negedge clk);

        // b = 0: check cycle only
        start_txn(32'd5, 32'd0);
        wait_done(lat);
        chk("b0_lat", 64'(lat), 64'd2);
        chk("b0_nupd", 64'(shq.size()), 64'd0);
        chk("b0_res", 64'(res_reg), 64'd0);
        @(negedge clk);

        // b = 1: one add
        start_txn(32'd7, 32'd1);
        wait_done(lat);
        chk("b1_lat", 64'(lat), 64'd3);
        chk("b1_nupd", 64'(shq.size()), 64'd1);
        chk("b1_sh_add", 64'({shq[0], addq[0]}), 64'({32'd1, 32'd1}));
        chk("b1_res", 64'(res_reg), 64'd7);
        @(negedge clk);

        // b = 0x80000000: zero-run skipping
        start_txn(32'd3, 32'h8000_0000);
        wait_done(lat);
        chk("msb_lat", 64'(lat), 64'd7);
        chk("msb_nupd", 64'(shq.size()), 64'd5);
        for (int i = 0; i < 5 && i < shq.size(); i++) begin
            chk($sformatf("msb_sh%0d", i), 64'(shq[i]), 64'(exp_sh[i]));
            chk($sformatf("msb_add%0d", i), 64'(addq[i]), (i == 4) ? 64'd1 : 64'd0);
        end
        chk("msb_count", 64'(dut.count), 64'd32);
        chk("msb_res", 64'(res_reg), 64'h8000_0000);
        @(negedge clk);

        // b = all ones: exit on count
        start_txn(32'd3, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("ones_lat", 64'(lat), 64'd34);
        chk("ones_nupd", 64'(shq.size()), 64'd32);
        ok_all = 1;
        foreach (shq[i]) if (shq[i] != 1 || addq[i] != 1) ok_all = 0;
        chk("ones_pattern", 64'(ok_all), 64'd1);
        chk("ones_count", 64'(dut.count), 64'd32);
        chk("ones_res", 64'(res_reg), 64'hFFFF_FFFD);
        @(negedge clk);

        // Backpressure in DONE
        ostream_rdy = 1'b0;
        start_txn(32'd9, 32'd6);
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {ostream_val, istream_rdy, a_en, b_en, result_en}, 5'b10000);
        end
        chk("bp_res", 64'(res_reg), 64'd54);
        ostream_rdy = 1'b1;
        @(negedge clk);
        chk("bp_release", {istream_rdy, ostream_val}, 2'b10);

        // Reset mid-CALC
        start_txn(32'd3, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", 64'(outs()), 64'd0);
        chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_idle", {istream_rdy, ostream_val}, 2'b10);
            @(negedge clk);
        end
        start_txn(32'd4, 32'd3);
        wait_done(lat);
        chk("b3_lat", 64'(lat), 64'd4);
        chk("b3_count", 64'(dut.count), 64'd2);
        chk("b3_res", 64'(res_reg), 64'd12);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
